// File: rtl/dp_arc_datapath.sv
// ============================================================================
// Module   : dp_arc_datapath
// Purpose  : ARC register bank, 16-function ALU, registered active-low flags,
//            optional serial SRL (enabled by DP_ARC_DATAPATH_SERIAL_SHIFT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module dp_arc_datapath #(
    parameter int DATAWIDTH_BUS               = 32,
    parameter int DATAWIDTH_BUS_REG_MIR_FIELD = 6,
    parameter int DATAWIDTH_ALU_SELECTION     = 4
) (
    input  logic                                   DP_CLOCK_50,
    input  logic                                   DP_Reset_InHigh,
    input  logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] DP_MUX_A_MIR,
    input  logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] DP_MUX_B_MIR,
    input  logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] DP_MUX_C_MIR,
    input  logic                                   DP_MUX_A_MIR_Selector,
    input  logic                                   DP_MUX_B_MIR_Selector,
    input  logic                                   DP_MUX_C_MIR_Selector,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0]     DP_ALU_Selection_In,
    input  logic                                   DP_MemRead_In,
    input  logic [DATAWIDTH_BUS-1:0]               DP_Data_In,
    output logic [DATAWIDTH_BUS-1:0]               DP_ABus_Out,
    output logic [DATAWIDTH_BUS-1:0]               DP_BBus_Out,
    output logic                                   DP_Negative_OutLow,
    output logic                                   DP_Zero_OutLow,
    output logic                                   DP_Overflow_OutLow,
    output logic                                   DP_Carry_OutLow,
    output logic                                   DP_Flags_Write_OutLow,
    output logic                                   DP_IR13_Out,
    output logic                                   DP_Busy_Out
);
    localparam int AW = DATAWIDTH_BUS_REG_MIR_FIELD;
    localparam int W  = DATAWIDTH_BUS;
    localparam logic [AW-1:0] c_ADDR_IR   = AW'(37);
    localparam logic [AW-1:0] c_ADDR_LAST = AW'(37);

    logic [W-1:0]  r_regs [1:37];
    logic [W-1:0]  w_ir;
    logic [AW-1:0] w_a_addr, w_b_addr, w_c_addr;
    logic [W-1:0]  w_a_data, w_b_data;
    logic [W-1:0]  w_alu;
    logic [W:0]    w_sum;
    logic          w_cc, w_v, w_c;
    logic          r_n, r_z, r_v, r_c, r_fw_n;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [W-1:0]  w_wr_data;
    logic          w_busy, w_srl_start, w_shift_done;
    logic [AW-1:0] w_sh_addr;
    logic [W-1:0]  w_sh_result;

    assign w_ir     = r_regs[c_ADDR_IR];
    assign w_a_addr = DP_MUX_A_MIR_Selector ? DP_MUX_A_MIR : {1'b0, w_ir[18:14]};
    assign w_b_addr = DP_MUX_B_MIR_Selector ? DP_MUX_B_MIR : {1'b0, w_ir[4:0]};
    assign w_c_addr = DP_MUX_C_MIR_Selector ? DP_MUX_C_MIR : {1'b0, w_ir[29:25]};

    // %r0 and the unmapped tail of the address space read as zero
    assign w_a_data = (w_a_addr != '0 && w_a_addr <= c_ADDR_LAST) ? r_regs[w_a_addr] : '0;
    assign w_b_data = (w_b_addr != '0 && w_b_addr <= c_ADDR_LAST) ? r_regs[w_b_addr] : '0;

    assign w_sum = {1'b0, w_a_data} + {1'b0, w_b_data};

    always_comb begin
        w_alu = '0;
        w_cc  = 1'b0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (DP_ALU_Selection_In)
            4'd0:  begin w_alu = w_a_data & w_b_data;    w_cc = 1'b1; end
            4'd1:  begin w_alu = w_a_data | w_b_data;    w_cc = 1'b1; end
            4'd2:  begin w_alu = ~(w_a_data | w_b_data); w_cc = 1'b1; end
            4'd3:  begin
                w_alu = w_sum[W-1:0];
                w_cc  = 1'b1;
                w_c   = w_sum[W];
                w_v   = (w_a_data[W-1] == w_b_data[W-1]) && (w_sum[W-1] != w_a_data[W-1]);
            end
            4'd4:  w_alu = w_a_data >> w_b_data[4:0];
            4'd5:  w_alu = w_a_data & w_b_data;
            4'd6:  w_alu = w_a_data | w_b_data;
            4'd7:  w_alu = ~(w_a_data | w_b_data);
            4'd8:  w_alu = w_sum[W-1:0];
            4'd9:  w_alu = w_a_data << 2;
            4'd10: w_alu = w_a_data << 10;
            4'd11: w_alu = {{(W-13){1'b0}}, w_a_data[12:0]};
            4'd12: w_alu = {{(W-13){w_a_data[12]}}, w_a_data[12:0]};
            4'd13: w_alu = w_a_data + W'(1);
            4'd14: w_alu = w_a_data + W'(4);
            default: w_alu = {{5{w_a_data[W-1]}}, w_a_data[W-1:5]};
        endcase
    end

`ifdef DP_ARC_DATAPATH_SERIAL_SHIFT_EN
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]   r_state, w_state_nxt;
    logic [W-1:0] r_sh_data;
    logic [4:0]   r_sh_cnt;
    logic [AW-1:0] r_sh_dst;

    assign w_srl_start = (r_state == c_ST_IDLE) && (DP_ALU_Selection_In == 4'd4) &&
                         !DP_MemRead_In && (w_b_data[4:0] != 5'd0);

    always_ff @(posedge DP_CLOCK_50) begin
        if (DP_Reset_InHigh) r_state <= c_ST_IDLE;
        else                 r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_srl_start) w_state_nxt = c_ST_SHIFT;
            default:    if (r_sh_cnt == 5'd1) w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy       = (r_state == c_ST_SHIFT);
        w_shift_done = (r_state == c_ST_SHIFT) && (r_sh_cnt == 5'd1);
    end

    always_ff @(posedge DP_CLOCK_50) begin
        if (DP_Reset_InHigh) begin
            r_sh_data <= '0;
            r_sh_cnt  <= '0;
            r_sh_dst  <= '0;
        end else if (w_srl_start) begin
            r_sh_data <= w_a_data;
            r_sh_cnt  <= w_b_data[4:0];
            r_sh_dst  <= w_c_addr;
        end else if (w_busy) begin
            r_sh_data <= r_sh_data >> 1;
            r_sh_cnt  <= r_sh_cnt - 5'd1;
        end
    end

    assign w_sh_addr   = r_sh_dst;
    assign w_sh_result = r_sh_data >> 1;
`else
    assign w_busy       = 1'b0;
    assign w_srl_start  = 1'b0;
    assign w_shift_done = 1'b0;
    assign w_sh_addr    = '0;
    assign w_sh_result  = '0;
`endif

    // While shifting, only the final shift step may write the bank
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = w_c_addr;
        w_wr_data = DP_MemRead_In ? DP_Data_In : w_alu;
        if (w_busy) begin
            w_wr_en   = w_shift_done;
            w_wr_addr = w_sh_addr;
            w_wr_data = w_sh_result;
        end else if (!w_srl_start) begin
            w_wr_en = 1'b1;
        end
        if (w_wr_addr == '0 || w_wr_addr > c_ADDR_LAST) w_wr_en = 1'b0;
    end

    always_ff @(posedge DP_CLOCK_50) begin
        if (DP_Reset_InHigh) begin
            for (int i = 1; i <= 37; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge DP_CLOCK_50) begin
        if (DP_Reset_InHigh) begin
            r_n    <= 1'b0;
            r_z    <= 1'b0;
            r_v    <= 1'b0;
            r_c    <= 1'b0;
            r_fw_n <= 1'b1;
        end else begin
            r_fw_n <= ~(w_cc && !w_busy);
            if (w_cc && !w_busy) begin
                r_n <= w_alu[W-1];
                r_z <= (w_alu == '0);
                r_v <= w_v;
                r_c <= w_c;
            end
        end
    end

    assign DP_ABus_Out           = w_a_data;
    assign DP_BBus_Out           = w_b_data;
    assign DP_Negative_OutLow    = ~r_n;
    assign DP_Zero_OutLow        = ~r_z;
    assign DP_Overflow_OutLow    = ~r_v;
    assign DP_Carry_OutLow       = ~r_c;
    assign DP_Flags_Write_OutLow = r_fw_n;
    assign DP_IR13_Out           = w_ir[13];
    assign DP_Busy_Out           = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_dp_arc_datapath.sv
// ============================================================================
// Module   : tb_dp_arc_datapath
// Purpose  : Directed self-checking bench for dp_arc_datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dp_arc_datapath;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  a_mir, b_mir, c_mir;
    logic        a_sel, b_sel, c_sel;
    logic [3:0]  alu;
    logic        mem_rd;
    logic [31:0] din;
    logic [31:0] abus, bbus;
    logic        n_l, z_l, v_l, c_l, fw_l, ir13, busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    dp_arc_datapath dut (
        .DP_CLOCK_50           (clk),
        .DP_Reset_InHigh       (rst),
        .DP_MUX_A_MIR          (a_mir),
        .DP_MUX_B_MIR          (b_mir),
        .DP_MUX_C_MIR          (c_mir),
        .DP_MUX_A_MIR_Selector (a_sel),
        .DP_MUX_B_MIR_Selector (b_sel),
        .DP_MUX_C_MIR_Selector (c_sel),
        .DP_ALU_Selection_In   (alu),
        .DP_MemRead_In         (mem_rd),
        .DP_Data_In            (din),
        .DP_ABus_Out           (abus),
        .DP_BBus_Out           (bbus),
        .DP_Negative_OutLow    (n_l),
        .DP_Zero_OutLow        (z_l),
        .DP_Overflow_OutLow    (v_l),
        .DP_Carry_OutLow       (c_l),
        .DP_Flags_Write_OutLow (fw_l),
        .DP_IR13_Out           (ir13),
        .DP_Busy_Out           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                         input logic [3:0] op);
        a_mir = a; b_mir = b; c_mir = c;
        a_sel = 1'b1; b_sel = 1'b1; c_sel = 1'b1;
        alu = op; mem_rd = 1'b0; din = '0;
    endtask

    task automatic load(input logic [5:0] addr, input logic [31:0] data);
        issue(6'd0, 6'd0, addr, 4'd5);
        mem_rd = 1'b1; din = data;
        step();
    endtask

    // Read through the A bus with a harmless non-CC op aimed at %r0
    task automatic rd(input logic [5:0] addr, output logic [31:0] data);
        issue(addr, 6'd0, 6'd0, 4'd5);
        #1;
        data = abus;
    endtask

    logic [3:0]  codes [9] = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd7, 4'd6};
    logic [31:0] exps  [9] = '{32'h00007FFC, 32'h007FFC00, 32'h00001FFF, 32'hFFFFFFFF,
                               32'h80002000, 32'h80002003, 32'hFC0000FF, 32'h7FFFE000,
                               32'h80001FFF};

    initial begin
        rst = 1'b1;
        issue(6'd0, 6'd0, 6'd0, 4'd5);
        step(); step();
        rst = 1'b0;

        // Reset in the middle of activity
        load(6'd1, 32'h55);
        load(6'd37, 32'h00002000);
        issue(6'd1, 6'd0, 6'd2, 4'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_n", n_l, 1); chk("rst_z", z_l, 1); chk("rst_v", v_l, 1); chk("rst_c", c_l, 1);
        chk("rst_fw", fw_l, 1); chk("rst_busy", busy, 0); chk("rst_ir13", ir13, 0);
        rd(6'd1, v); chk("rst_r1", v, 0);
        rd(6'd2, v); chk("rst_r2", v, 0);

        // ADDCC signed overflow
        load(6'd1, 32'h7FFFFFFF);
        load(6'd2, 32'h00000001);
        issue(6'd1, 6'd2, 6'd3, 4'd3);
        #1;
        chk("addcc_abus", abus, 32'h7FFFFFFF);
        chk("addcc_bbus", bbus, 32'h00000001);
        step();
        chk("addcc_n", n_l, 0); chk("addcc_z", z_l, 1); chk("addcc_v", v_l, 0); chk("addcc_c", c_l, 1);
        chk("addcc_fw", fw_l, 0);
        rd(6'd3, v); chk("addcc_r3", v, 32'h80000000);
        step();
        chk("addcc_fw_pulse", fw_l, 1);

        // ANDCC zero result, then a non-CC ADD leaves flags alone
        load(6'd4, 32'hF0);
        load(6'd5, 32'h0F);
        issue(6'd4, 6'd5, 6'd6, 4'd0);
        step();
        chk("andcc_n", n_l, 1); chk("andcc_z", z_l, 0); chk("andcc_v", v_l, 1); chk("andcc_c", c_l, 1);
        chk("andcc_fw", fw_l, 0);
        load(6'd7, 32'hFFFFFFFF);
        load(6'd8, 32'h00000001);
        issue(6'd7, 6'd8, 6'd9, 4'd8);
        step();
        chk("add_z_kept", z_l, 0); chk("add_c_kept", c_l, 1); chk("add_fw", fw_l, 1);
        rd(6'd9, v); chk("add_r9", v, 0);

        // ADDCC carry out with zero result
        issue(6'd7, 6'd8, 6'd10, 4'd3);
        step();
        chk("carry_n", n_l, 1); chk("carry_z", z_l, 0); chk("carry_v", v_l, 1); chk("carry_c", c_l, 0);

        // IR-field addressing: 0x8A004002 decodes rd=5, rs1=IR[18:14]=1, rs2=2
        load(6'd1, 32'h100);
        load(6'd2, 32'h23);
        load(6'd37, 32'h8A004002);
        chk("ir13_lo", ir13, 0);
        issue(6'd9, 6'd9, 6'd11, 4'd8);
        a_sel = 1'b0; b_sel = 1'b0; c_sel = 1'b0;
        #1;
        chk("ir_abus", abus, 32'h100);
        chk("ir_bbus", bbus, 32'h23);
        step();
        rd(6'd5, v);  chk("ir_rd5", v, 32'h123);
        rd(6'd11, v); chk("ir_mir_c_unused", v, 0);
        load(6'd37, 32'h00002000);
        chk("ir13_hi", ir13, 1);

        // %r0 and unmapped addresses
        load(6'd0, 32'h1234);
        load(6'd40, 32'h1234);
        rd(6'd0, v);  chk("r0_zero", v, 0);
        rd(6'd40, v); chk("a40_zero", v, 0);

        // Non-CC ALU functions on A=0x80001FFF, B=%r0
        load(6'd20, 32'h80001FFF);
        for (int i = 0; i < 9; i++) begin
            issue(6'd20, 6'd0, 6'd21, codes[i]);
            step();
            rd(6'd21, v);
            chk($sformatf("alu%0d", codes[i]), v, exps[i]);
        end

        // Same-cycle read of a register being written returns the old value
        issue(6'd20, 6'd0, 6'd20, 4'd13);
        #1;
        chk("rw_old", abus, 32'h80001FFF);
        step();
        rd(6'd20, v); chk("rw_new", v, 32'h80002000);

        // SRL
        load(6'd12, 32'h80000000);
        load(6'd13, 32'h00000003);
`ifdef DP_ARC_DATAPATH_SERIAL_SHIFT_EN
        issue(6'd12, 6'd13, 6'd14, 4'd4);
        step();
        chk("srl_busy1", busy, 1);
        // Garbage MIR while busy must be ignored
        issue(6'd14, 6'd0, 6'd14, 4'd3);
        mem_rd = 1'b1; din = 32'hDEADBEEF;
        #1;
        chk("srl_not_yet", abus, 0);
        step();
        chk("srl_busy2", busy, 1);
        step();
        chk("srl_busy3", busy, 1);
        chk("srl_no_strobe", fw_l, 1);
        step();
        chk("srl_busy_end", busy, 0);
        rd(6'd14, v); chk("srl_result", v, 32'h10000000);

        issue(6'd12, 6'd0, 6'd15, 4'd4);
        step();
        chk("srl0_busy", busy, 0);
        rd(6'd15, v); chk("srl0_result", v, 32'h80000000);

        issue(6'd12, 6'd13, 6'd16, 4'd4);
        step();
        rd(6'd0, v);
        step();
        chk("srl_abort_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("srl_abort_idle", busy, 0);
        rd(6'd16, v); chk("srl_abort_r16", v, 0);
        step(); step(); step();
        rd(6'd16, v); chk("srl_abort_late", v, 0);
`else
        issue(6'd12, 6'd13, 6'd14, 4'd4);
        step();
        chk("srl_busy", busy, 0);
        rd(6'd14, v); chk("srl_result", v, 32'h10000000);
        issue(6'd12, 6'd0, 6'd15, 4'd4);
        step();
        chk("srl0_busy", busy, 0);
        rd(6'd15, v); chk("srl0_result", v, 32'h80000000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
